// File: rtl/ptr.sv
// PDP-6 paper tape reader (device 104): assembles tape frames into 36-bit words; flag after FRAME_CYCLES+2 (alpha) / 6*(FRAME_CYCLES+1)+1 (binary) cycles.
// Backpressure: frames are taken only when tape_valid is high in FETCH; with no tape the reader waits in FETCH indefinitely.
module ptr #(
  parameter int         FRAME_CYCLES = 4,
  parameter logic [3:9] DEVCODE      = 7'o21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_reset,
  input  logic [3:9]  iobus_ios,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_iob_fm_status,
  input  logic        iobus_iob_fm_datai,
  input  logic [0:35] iobus_iob_in,
  output logic [0:35] iobus_iob_out,
  output logic [1:7]  iobus_pi_req,
  input  logic        tape_valid,
  input  logic [7:0]  tape_data,
  output logic        tape_ready
);

  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STEP, FETCH, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [0:35]   word, word_n;
  logic [0:5]    fcnt, fcnt_n;
  logic [2:0]    pia, pia_n;
  logic          flag, flag_n;
  logic          busy, busy_n;
  logic          b, b_n;
  logic          datai_d;

  logic rst, sel, clr, setp, datai_now, datai_fall, start, take;
  logic unused_iob_in;

  assign rst        = reset | iobus_iob_reset;
  assign sel        = (iobus_ios == DEVCODE);
  assign clr        = sel & iobus_cono_clear;
  assign setp       = sel & iobus_cono_set;
  assign datai_now  = sel & iobus_iob_fm_datai;
  assign datai_fall = datai_d & ~datai_now;
  assign start      = (setp & iobus_iob_in[31]) | datai_fall;
  assign take       = (state == FETCH) & tape_valid & ~rst & ~clr;
  assign tape_ready = take;
  assign unused_iob_in = ^iobus_iob_in[0:29];

  always_comb begin
    state_n = state;
    timer_n = timer;
    word_n  = word;
    fcnt_n  = fcnt;
    pia_n   = pia;
    flag_n  = flag;
    busy_n  = busy;
    b_n     = b;

    case (state)
      IDLE: begin
        if (busy) begin
          state_n = STEP;
          timer_n = TIMER_LOAD;
        end
      end
      STEP: begin
        if (timer == '0) state_n = FETCH;
        else             timer_n = timer - TW'(1);
      end
      FETCH: begin
        if (take) begin
          if (!b) begin
            word_n  = {28'b0, tape_data};
            state_n = DONE;
          end else if (tape_data[7]) begin
            word_n = {word[6:35], tape_data[5:0]};
            fcnt_n = fcnt + 6'd1;
            if (fcnt == 6'd5) begin
              state_n = DONE;
            end else begin
              state_n = STEP;
              timer_n = TIMER_LOAD;
            end
          end else begin
            state_n = STEP;
            timer_n = TIMER_LOAD;
          end
          if (state_n == DONE) begin
            flag_n = 1'b1;
            busy_n = 1'b0;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Bus operations override the reader; clear is applied before set.
    if (clr) begin
      pia_n  = 3'd0;
      b_n    = 1'b0;
      busy_n = 1'b0;
      flag_n = 1'b0;
      fcnt_n = 6'd0;
    end
    if (setp) begin
      b_n    = b_n | iobus_iob_in[30];
      busy_n = busy_n | iobus_iob_in[31];
      flag_n = flag_n | iobus_iob_in[32];
      pia_n  = pia_n | iobus_iob_in[33:35];
    end
    if (datai_fall) begin
      flag_n = 1'b0;
      busy_n = 1'b1;
    end
    if (start) begin
      word_n  = 36'd0;
      fcnt_n  = 6'd0;
      state_n = IDLE;
    end else if (!busy_n && state_n != DONE) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      word    <= 36'd0;
      fcnt    <= 6'd0;
      pia     <= 3'd0;
      flag    <= 1'b0;
      busy    <= 1'b0;
      b       <= 1'b0;
      datai_d <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      word    <= word_n;
      fcnt    <= fcnt_n;
      pia     <= pia_n;
      flag    <= flag_n;
      busy    <= busy_n;
      b       <= b_n;
      datai_d <= datai_now;
    end
  end

  always_comb begin
    iobus_iob_out = 36'd0;
    if (sel & iobus_iob_fm_status) iobus_iob_out = iobus_iob_out | {30'b0, b, busy, flag, pia};
    if (datai_now)                 iobus_iob_out = iobus_iob_out | word;
  end

  always_comb begin
    iobus_pi_req = 7'd0;
    for (int i = 1; i <= 7; i++) begin
      iobus_pi_req[i] = flag & (pia == 3'(i));
    end
  end

endmodule

// File: tb/tb_ptr.sv
// Randomised and directed bench for the paper tape reader against a transaction-level model.
module tb_ptr;
  localparam int         FC  = 4;
  localparam logic [6:0] DEV = 7'o21;

  logic        clk = 1'b0;
  logic        reset = 1'b1, iob_reset = 1'b0;
  logic [3:9]  ios = 7'd0;
  logic        cono_clear = 1'b0, cono_set = 1'b0, fm_status = 1'b0, fm_datai = 1'b0;
  logic [0:35] iob_in = 36'd0;
  logic [0:35] iob_out;
  logic [1:7]  pi_req;
  logic        tape_valid = 1'b0;
  logic [7:0]  tape_data = 8'd0;
  logic        tape_ready;

  ptr #(.FRAME_CYCLES(FC), .DEVCODE(DEV)) dut (
    .clk(clk), .reset(reset), .iobus_iob_reset(iob_reset), .iobus_ios(ios),
    .iobus_cono_clear(cono_clear), .iobus_cono_set(cono_set),
    .iobus_iob_fm_status(fm_status), .iobus_iob_fm_datai(fm_datai),
    .iobus_iob_in(iob_in), .iobus_iob_out(iob_out), .iobus_pi_req(pi_req),
    .tape_valid(tape_valid), .tape_data(tape_data), .tape_ready(tape_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0, gaps = 0, tr_seen = 0;
  logic [7:0] q[$];

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o required %0o", nm, act, exp);
    end
  endtask

  // Reader model: after a start the first frame is sampled FC+1 cycles later,
  // each further frame FC cycles after the previous one was taken.
  bit         m_b, m_busy, m_flag, m_dprev;
  logic [2:0] m_pia;
  logic [35:0] m_word;
  int m_cnt, m_wait;

  always @(negedge clk) begin : cmp
    logic rst, sel, clr, setp, dnow, cons, fin, start;
    logic [35:0] eout, inv, coni_v;
    logic [6:0] epi;
    rst  = reset | iob_reset;
    sel  = (ios == DEV);
    clr  = sel & cono_clear;
    setp = sel & cono_set;
    dnow = sel & fm_datai;
    inv  = iob_in;
    cons = m_busy && (m_wait == 0) && tape_valid && !clr && !rst;
    tr_seen = tape_ready;
    coni_v = 36'(m_b) * 32 + 36'(m_busy) * 16 + 36'(m_flag) * 8 + 36'(m_pia);
    if (chk_en) begin
      check("tape_ready", 36'(tape_ready), 36'(cons));
      epi = (m_flag && m_pia != 0) ? (7'b1000000 >> (m_pia - 3'd1)) : 7'd0;
      check("pi_req", 36'(pi_req), 36'(epi));
      eout = 36'd0;
      if (sel && fm_status) eout = eout | coni_v;
      if (dnow) eout = eout | m_word;
      check("iob_out", iob_out, eout);
    end
    if (rst) begin
      m_b = 0; m_busy = 0; m_flag = 0; m_dprev = 0; m_pia = 0;
      m_word = 0; m_cnt = 0; m_wait = 0;
    end else begin
      fin = 0;
      start = 0;
      if (cons) begin
        if (!m_b) begin
          m_word = 36'(tape_data);
          fin = 1;
        end else if (tape_data[7]) begin
          m_word = (m_word << 6) | 36'(tape_data & 8'h3f);
          m_cnt++;
          if (m_cnt == 6) fin = 1; else m_wait = FC;
        end else begin
          m_wait = FC;
        end
        if (fin) begin m_busy = 0; m_flag = 1; end
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end
      if (clr) begin m_pia = 0; m_b = 0; m_busy = 0; m_flag = 0; m_cnt = 0; end
      if (setp) begin
        m_b = m_b | inv[5];
        m_busy = m_busy | inv[4];
        m_flag = m_flag | inv[3];
        m_pia = m_pia | inv[2:0];
        if (inv[4]) start = 1;
      end
      if (m_dprev && !dnow) begin m_flag = 0; m_busy = 1; start = 1; end
      m_dprev = dnow;
      if (start) begin m_word = 0; m_cnt = 0; m_wait = FC + 1; end
    end
  end

  // Host tape stream: the front frame is offered until the reader takes it.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tr_seen && q.size() > 0) void'(q.pop_front());
      tape_valid = (q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      tape_data  = (q.size() > 0) ? q[0] : 8'h00;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic cono(input bit clr, input bit set, input logic [5:0] val);
    tick;
    ios = DEV; cono_clear = clr; cono_set = set; iob_in = 36'(val);
    tick;
    cono_clear = 0; cono_set = 0; iob_in = 36'd0;
  endtask

  task automatic coni(input logic [6:0] dev, output logic [35:0] v);
    tick;
    ios = dev; fm_status = 1;
    @(negedge clk); v = iob_out;
    tick;
    fm_status = 0; ios = DEV;
  endtask

  task automatic datai(input int hold, output logic [35:0] v);
    tick;
    ios = DEV; fm_datai = 1;
    repeat (hold - 1) tick;
    @(negedge clk); v = iob_out;
    tick;
    fm_datai = 0;
  endtask

  // Cycles from the CONO-set edge to the edge that raises flag; -1 on timeout.
  task automatic wait_flag(output int lat);
    int n;
    n = 0; lat = -1;
    ios = DEV; fm_status = 1;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (iob_out[32] === 1'b1) begin lat = n - 1; break; end
    end
    tick;
    fm_status = 0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL flag_wait: got no flag within 3000 cycles required flag");
    end
  endtask

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: got timeout required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [35:0] v, ew;
    logic [7:0] fr[$];
    int lat, skips, n;
    bit bm, cl;
    logic [2:0] pa;
    logic [7:0] f;

    @(posedge clk); #1 chk_en = 1;
    tick; tick;
    reset = 0;
    coni(DEV, v);               check("reset_coni", v, 36'd0);
    check("reset_pi", 36'(pi_req), 36'd0);

    // Alpha read, pia 5
    q.push_back(8'o241);
    cono(0, 1, 6'o25);
    wait_flag(lat);             check("alpha_lat", 36'(lat), 36'(FC + 2));
    check("alpha_pi", 36'(pi_req), 36'(7'b0000100));
    datai(1, v);                check("alpha_word", v, 36'o000000000241);
    coni(DEV, v);               check("after_datai", v, 36'o25);

    // Stall with no tape, then abort
    repeat (40) tick;
    coni(DEV, v);               check("stall_busy", v, 36'o25);
    cono(1, 0, 6'o00);
    coni(DEV, v);               check("abort_coni", v, 36'd0);
    q.push_back(8'o177);
    repeat (20) tick;
    check("abort_noconsume", 36'(q.size()), 36'd1);
    q.delete();
    tick;

    // Binary read with one skipped frame
    q = '{8'o201, 8'o202, 8'o203, 8'o000, 8'o204, 8'o205, 8'o206};
    cono(0, 1, 6'o67);
    wait_flag(lat);             check("bin_skip_lat", 36'(lat), 36'(7 * (FC + 1) + 1));
    datai(2, v);                check("bin_word", v, 36'o010203040506);
    cono(1, 0, 6'o00);

    // Binary without skips, pia 3
    q = '{8'o277, 8'o200, 8'o277, 8'o200, 8'o252, 8'o325};
    cono(0, 1, 6'o63);
    wait_flag(lat);             check("bin_lat", 36'(lat), 36'(6 * (FC + 1) + 1));
    coni(DEV, v);               check("coni_53", v, 36'o53);
    coni(7'o22, v);             check("coni_other_dev", v, 36'd0);

    // Clear and set together: set wins
    q.push_back(8'o123);
    cono(1, 1, 6'o20);
    coni(DEV, v);               check("clrset_coni", v, 36'o20);
    repeat (20) tick;
    coni(DEV, v);               check("clrset_done", v, 36'o10);
    check("clrset_pi", 36'(pi_req), 36'd0);

    // Reset in FETCH after three binary frames
    q = '{8'o301, 8'o302, 8'o303};
    cono(1, 1, 6'o66);
    n = 0;
    while (q.size() > 0 && n < 500) begin tick; n++; end
    check("midread_drain", 36'(q.size()), 36'd0);
    repeat (3) tick;
    reset = 1;
    q.push_back(8'o377);
    tick; tick;
    reset = 0;
    repeat (10) tick;
    check("reset_noconsume", 36'(q.size()), 36'd1);
    coni(DEV, v);               check("midreset_coni", v, 36'd0);
    check("midreset_pi", 36'(pi_req), 36'd0);
    q.delete();
    tick;

    // Bus I/O reset during a stalled read
    cono(0, 1, 6'o25);
    repeat (10) tick;
    iob_reset = 1;
    tick;
    iob_reset = 0;
    coni(DEV, v);               check("iobreset_coni", v, 36'd0);

    // Randomised reads
    for (int it = 0; it < 25; it++) begin
      cono(1, 0, 6'o00);
      q.delete();
      gaps = ($urandom_range(0, 1) == 1);
      bm = ($urandom_range(0, 1) == 1);
      pa = 3'($urandom_range(0, 7));
      cl = ($urandom_range(0, 1) == 1);
      fr.delete();
      ew = 36'd0;
      skips = 0;
      if (!bm) begin
        f = 8'($urandom_range(0, 255));
        fr.push_back(f);
        ew = 36'(f);
      end else begin
        for (int k = 0; k < 6; k++) begin
          while ($urandom_range(0, 3) == 0) begin
            fr.push_back(8'($urandom_range(0, 127)));
            skips++;
          end
          f = 8'($urandom_range(128, 255));
          fr.push_back(f);
          ew = (ew << 6) | 36'(f & 8'h3f);
        end
      end
      foreach (fr[k]) q.push_back(fr[k]);
      cono(cl, 1, {bm, 1'b1, 1'b0, pa});
      wait_flag(lat);
      if (!gaps) check("rand_lat", 36'(lat), bm ? 36'((6 + skips) * (FC + 1) + 1) : 36'(FC + 2));
      datai($urandom_range(1, 3), v);
      check("rand_word", v, ew);
    end
    gaps = 0;
    cono(1, 0, 6'o00);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
